// File: rtl/csr_access_arbiter.sv
// csr_access_arbiter
//   Shares the single CSR regfile access port between NumReq requesters
//   (commit-stage CSR unit, debug abstract commands, SoC config bus).
//   Round-robin grant with one transaction in flight at a time. Each op is
//   issued to the regfile for exactly one cycle, and the response is returned
//   to its owner one cycle later. A successful non-read op is followed by
//   HoldCycles quiet cycles so that regfile side effects can settle.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_valid_i         per-requester request valid
//   req_ready_o         one-hot accept strobe (combinational, IDLE only)
//   req_cmd_i           NumReq x 2 bit command: 00 read, 01 write, 10 set, 11 clear
//   req_addr_i          NumReq x 12 bit CSR address
//   req_wdata_i         NumReq x XLEN bit operand
//   rsp_valid_o         one-hot response strobe
//   rsp_rdata_o         read data returned to the owner (0 outside a response)
//   rsp_err_o           CSR exception for the returned access
//   halt_i              regfile halt; blocks new grants
//   csr_valid_o         one-cycle access strobe to the regfile
//   csr_cmd_o           command to the regfile
//   csr_addr_o          address to the regfile
//   csr_wdata_o         operand to the regfile
//   csr_rdata_i         regfile read data, valid with csr_valid_o
//   csr_exc_i           regfile exception, valid with csr_valid_o
//   busy_o              a transaction or quiet window is in progress
module csr_access_arbiter #(
    parameter int NumReq     = 3,
    parameter int XLEN       = 64,
    parameter int HoldCycles = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NumReq-1:0]        req_valid_i,
    output logic [NumReq-1:0]        req_ready_o,
    input  logic [2*NumReq-1:0]      req_cmd_i,
    input  logic [12*NumReq-1:0]     req_addr_i,
    input  logic [XLEN*NumReq-1:0]   req_wdata_i,
    output logic [NumReq-1:0]        rsp_valid_o,
    output logic [XLEN-1:0]          rsp_rdata_o,
    output logic                     rsp_err_o,
    input  logic                     halt_i,
    output logic                     csr_valid_o,
    output logic [1:0]               csr_cmd_o,
    output logic [11:0]              csr_addr_o,
    output logic [XLEN-1:0]          csr_wdata_o,
    input  logic [XLEN-1:0]          csr_rdata_i,
    input  logic                     csr_exc_i,
    output logic                     busy_o
);

    localparam int          PtrW  = $clog2(NumReq);
    localparam int          HoldW = (HoldCycles > 1) ? $clog2(HoldCycles + 1) : 1;
    localparam int unsigned NR    = NumReq;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, HOLD} state_t;

    state_t            state;
    logic [PtrW-1:0]   rr_ptr;
    logic [PtrW-1:0]   owner;
    logic [1:0]        cmd_q;
    logic [11:0]       addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q;
    logic              exc_q;
    logic [HoldW-1:0]  hold_cnt;

    logic [PtrW-1:0]   winner;
    logic [PtrW-1:0]   idx;
    logic              found;
    logic              grant;
    logic [1:0]        sel_cmd;
    logic [11:0]       sel_addr;
    logic [XLEN-1:0]   sel_wdata;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            idx = PtrW'((32'(rr_ptr) + i) % NR);
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        sel_cmd   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (winner == PtrW'(i)) begin
                sel_cmd   = req_cmd_i[2*i +: 2];
                sel_addr  = req_addr_i[12*i +: 12];
                sel_wdata = req_wdata_i[XLEN*i +: XLEN];
            end
        end
    end

    assign grant = (state == IDLE) && !halt_i && found;

    // Gated by rst_i so that every output reads 0 while reset is held.
    always_comb begin
        req_ready_o = '0;
        if (grant && !rst_i) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (state == RESP) begin
            rsp_valid_o[owner] = 1'b1;
        end
    end

    assign rsp_rdata_o = (state == RESP) ? rdata_q : '0;
    assign rsp_err_o   = (state == RESP) && exc_q;
    assign csr_valid_o = (state == ISSUE);
    assign csr_cmd_o   = csr_valid_o ? cmd_q   : '0;
    assign csr_addr_o  = csr_valid_o ? addr_q  : '0;
    assign csr_wdata_o = csr_valid_o ? wdata_q : '0;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            exc_q    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        cmd_q   <= sel_cmd;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        owner   <= winner;
                        rr_ptr  <= (winner == PtrW'(NumReq - 1)) ? '0 : winner + 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    rdata_q <= csr_rdata_i;
                    exc_q   <= csr_exc_i;
                    state   <= RESP;
                end
                RESP: begin
                    if (cmd_q != 2'b00 && !exc_q && HoldCycles > 0) begin
                        hold_cnt <= HoldW'(HoldCycles);
                        state    <= HOLD;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt <= 1) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Scoreboard bench for csr_access_arbiter. A cycle-level reference model in
// the stimulus process decides grants from the arbitration rules (earliest
// free cycle, round-robin pointer) and queues the expected grant, regfile
// access and response. A separate monitor pops and compares whenever the DUT
// presents the corresponding strobe.
module tb_csr_access_arbiter;

    localparam int N  = 3;
    localparam int XL = 64;
    localparam int HC = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [N-1:0]      req_valid_i = '0;
    logic [N-1:0]      req_ready_o;
    logic [2*N-1:0]    req_cmd_i = '0;
    logic [12*N-1:0]   req_addr_i = '0;
    logic [XL*N-1:0]   req_wdata_i = '0;
    logic [N-1:0]      rsp_valid_o;
    logic [XL-1:0]     rsp_rdata_o;
    logic              rsp_err_o;
    logic              halt_i = 1'b0;
    logic              csr_valid_o;
    logic [1:0]        csr_cmd_o;
    logic [11:0]       csr_addr_o;
    logic [XL-1:0]     csr_wdata_o;
    logic [XL-1:0]     csr_rdata_i = '0;
    logic              csr_exc_i = 1'b0;
    logic              busy_o;

    csr_access_arbiter #(.NumReq(N), .XLEN(XL), .HoldCycles(HC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .halt_i(halt_i),
        .csr_valid_o(csr_valid_o), .csr_cmd_o(csr_cmd_o), .csr_addr_o(csr_addr_o),
        .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i), .csr_exc_i(csr_exc_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int unsigned cyc; logic [N-1:0] who; } gnt_t;
    typedef struct { int unsigned cyc; logic [1:0] cmd; logic [11:0] addr; logic [XL-1:0] wdata; } iss_t;
    typedef struct { int unsigned cyc; logic [N-1:0] who; logic [XL-1:0] rdata; logic err; } rsp_t;
    typedef struct { int unsigned cyc; logic busy; } bsy_t;

    gnt_t gq[$];
    iss_t iq[$];
    rsp_t rq[$];
    bsy_t bq[$];

    int checks = 0;
    int fails  = 0;

    // Reference model state
    int unsigned cyc = 0;
    int unsigned free_at = 0;
    int          rr = 0;
    bit          r_valid[N];
    logic [1:0]  r_cmd[N];
    logic [11:0] r_addr[N];
    logic [XL-1:0] r_wdata[N];
    bit          persist[N];
    bit          halt_v = 0;
    bit          rst_v = 1;
    bit          pend = 0;
    logic [XL-1:0] pend_rdata;
    bit          pend_exc;
    bit          ovr = 0;
    logic [XL-1:0] ovr_rdata;
    bit          ovr_exc;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic set_req(int i, logic [1:0] c, logic [11:0] a, logic [XL-1:0] d);
        r_valid[i] = 1;
        r_cmd[i]   = c;
        r_addr[i]  = a;
        r_wdata[i] = d;
    endtask

    // One clock cycle: drive the inputs for this cycle and advance the model.
    task automatic tick();
        bit any;
        int w;
        logic [XL-1:0] rd;
        bit ex;
        @(posedge clk_i);
        #1;
        cyc++;
        rst_i  = rst_v;
        halt_i = halt_v;
        for (int i = 0; i < N; i++) begin
            req_valid_i[i]            = r_valid[i];
            req_cmd_i[2*i +: 2]       = r_cmd[i];
            req_addr_i[12*i +: 12]    = r_addr[i];
            req_wdata_i[XL*i +: XL]   = r_wdata[i];
        end
        if (pend) begin
            csr_rdata_i = pend_rdata;
            csr_exc_i   = pend_exc;
        end else begin
            csr_rdata_i = {$urandom, $urandom};
            csr_exc_i   = 1'($urandom_range(0, 1));
        end
        pend = 0;
        if (rst_v) begin
            gq.delete();
            iq.delete();
            rq.delete();
            rr      = 0;
            free_at = cyc + 1;
            bq.push_back('{cyc, 1'b0});
            return;
        end
        bq.push_back('{cyc, cyc < free_at});
        any = 0;
        for (int i = 0; i < N; i++) any |= r_valid[i];
        if (cyc >= free_at && !halt_v && any) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (rr + k) % N;
                if (w < 0 && r_valid[j]) w = j;
            end
            if (ovr) begin
                rd = ovr_rdata;
                ex = ovr_exc;
            end else begin
                rd = {$urandom, $urandom};
                ex = ($urandom_range(0, 3) == 0);
            end
            ovr = 0;
            gq.push_back('{cyc, N'(1) << w});
            iq.push_back('{cyc + 1, r_cmd[w], r_addr[w], r_wdata[w]});
            rq.push_back('{cyc + 2, N'(1) << w, rd, ex});
            pend       = 1;
            pend_rdata = rd;
            pend_exc   = ex;
            free_at    = cyc + 3 + ((r_cmd[w] != 2'b00 && !ex) ? HC : 0);
            rr         = (w + 1) % N;
            if (!persist[w]) r_valid[w] = 0;
        end
    endtask

    task automatic rand_policy();
        for (int i = 0; i < N; i++) begin
            if (!r_valid[i]) begin
                if ($urandom_range(0, 3) == 0)
                    set_req(i, 2'($urandom_range(0, 3)), 12'($urandom), {$urandom, $urandom});
            end else if ($urandom_range(0, 19) == 0) begin
                r_valid[i] = 0;
            end
        end
        halt_v = ($urandom_range(0, 9) == 0);
        rst_v  = ($urandom_range(0, 199) == 0);
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            r_valid[i] = 0;
            persist[i] = 0;
        end
    endtask

    // Monitor: compares DUT strobes against the queued expectations.
    always @(negedge clk_i) begin
        gnt_t g;
        iss_t s;
        rsp_t r;
        bsy_t b;
        if (cyc > 0) begin
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                chk("grant_missing_cyc", cyc, gq[0].cyc);
                void'(gq.pop_front());
            end
            while (iq.size() > 0 && iq[0].cyc < cyc) begin
                chk("issue_missing_cyc", cyc, iq[0].cyc);
                void'(iq.pop_front());
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                chk("rsp_missing_cyc", cyc, rq[0].cyc);
                void'(rq.pop_front());
            end
            if (rst_i) begin
                chk("rst_ctl", 64'({req_ready_o, rsp_valid_o, rsp_err_o, csr_valid_o,
                                    csr_cmd_o, csr_addr_o, busy_o}), 0);
                chk("rst_data", rsp_rdata_o | csr_wdata_o, 0);
            end else begin
                if (req_ready_o != '0) begin
                    if (gq.size() == 0) begin
                        chk("grant_unexpected", 64'(req_ready_o), 0);
                    end else begin
                        g = gq.pop_front();
                        chk("grant_cyc", cyc, g.cyc);
                        chk("grant_who", 64'(req_ready_o), 64'(g.who));
                    end
                end
                if (csr_valid_o) begin
                    if (iq.size() == 0) begin
                        chk("issue_unexpected", 64'(csr_valid_o), 0);
                    end else begin
                        s = iq.pop_front();
                        chk("issue_cyc", cyc, s.cyc);
                        chk("issue_cmd", 64'(csr_cmd_o), 64'(s.cmd));
                        chk("issue_addr", 64'(csr_addr_o), 64'(s.addr));
                        chk("issue_wdata", csr_wdata_o, s.wdata);
                    end
                end
                if (rsp_valid_o != '0) begin
                    if (rq.size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_valid_o), 0);
                    end else begin
                        r = rq.pop_front();
                        chk("rsp_cyc", cyc, r.cyc);
                        chk("rsp_who", 64'(rsp_valid_o), 64'(r.who));
                        chk("rsp_rdata", rsp_rdata_o, r.rdata);
                        chk("rsp_err", 64'(rsp_err_o), 64'(r.err));
                    end
                end else begin
                    chk("rsp_idle_rdata", rsp_rdata_o, 0);
                    chk("rsp_idle_err", 64'(rsp_err_o), 0);
                end
            end
            if (bq.size() > 0) begin
                b = bq.pop_front();
                chk("busy", 64'(busy_o), 64'(b.busy));
            end
        end
    end

    initial begin
        clear_reqs();
        // Reset
        rst_v = 1;
        repeat (2) tick();
        rst_v = 0;
        tick();

        // Single read from requester 1
        set_req(1, 2'b00, 12'h300, '0);
        ovr = 1; ovr_rdata = 64'hA00; ovr_exc = 0;
        tick();
        repeat (4) tick();

        // Round-robin with all requesters continuously valid
        for (int i = 0; i < N; i++) begin
            persist[i] = 1;
            set_req(i, 2'b00, 12'(12'h100 + i), '0);
        end
        repeat (12) tick();
        clear_reqs();
        repeat (3) tick();

        // Write quiet window
        set_req(0, 2'b01, 12'h341, 64'h8000_1000);
        ovr = 1; ovr_rdata = 64'h5; ovr_exc = 0;
        tick();
        set_req(2, 2'b00, 12'h342, '0);
        repeat (8) tick();

        // Faulting write skips the quiet window
        set_req(2, 2'b01, 12'hF11, 64'h5);
        ovr = 1; ovr_rdata = 64'h77; ovr_exc = 1;
        tick();
        set_req(0, 2'b00, 12'h305, '0);
        repeat (6) tick();

        // Halt blocks grants
        halt_v = 1;
        set_req(0, 2'b00, 12'h344, '0);
        repeat (5) tick();
        halt_v = 0;
        repeat (4) tick();

        // Reset during ISSUE, then pointer restarts at 0
        set_req(0, 2'b00, 12'h340, '0);
        tick();
        rst_v = 1;
        tick();
        rst_v = 0;
        set_req(0, 2'b00, 12'h340, '0);
        set_req(1, 2'b00, 12'h341, '0);
        repeat (8) tick();

        // Randomised traffic
        repeat (3000) begin
            rand_policy();
            tick();
        end

        // Drain
        clear_reqs();
        rst_v  = 0;
        halt_v = 0;
        repeat (10) tick();
        @(negedge clk_i);
        #1;
        chk("queues_drained", 64'(gq.size() + iq.size() + rq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
